// File: rtl/prog_loader.sv
// prog_loader
//   Receives a program image over a byte stream and writes it into
//   instruction memory one 32-bit word at a time. The CPU is held in reset
//   until the whole image has arrived and its XOR checksum matches.
//
//   Stream layout: N_lo, N_hi (16-bit word count N), 4*N data bytes with
//   each word little-endian, then one checksum byte. The checksum is the
//   XOR of the data bytes only.
//
// Ports
//   clk        in   sole clock, all state updates on the rising edge
//   reset      in   synchronous, active-low reset
//   byte_valid in   an incoming byte is present
//   byte_data  in   [7:0] incoming byte value
//   byte_ready out  the byte is accepted this cycle (valid && ready)
//   write_en   out  one-cycle instruction memory write strobe
//   address    out  [31:0] instruction memory byte address (word_idx*4)
//   write_inst out  [31:0] word being written, held between writes
//   cpu_hold   out  keeps the CPU in reset until the load succeeds
//   load_done  out  program loaded and checksum verified
//   load_err   out  oversize length or checksum failure
module prog_loader #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        write_en,
  output logic [31:0] address,
  output logic [31:0] write_inst,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  // Compared against a 17-bit length so the check never wraps.
  localparam logic [16:0] MAX_WORDS = 17'(MEM_BYTES / 4);

  localparam logic [2:0] LEN_LO = 3'd0;
  localparam logic [2:0] LEN_HI = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] CHK    = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERR    = 3'd6;

  logic [2:0]  state_reg, state_next;
  logic [15:0] n_reg, n_next;
  logic [15:0] word_idx_reg, word_idx_next;
  logic [1:0]  byte_idx_reg, byte_idx_next;
  logic [7:0]  chk_reg, chk_next;
  logic [31:0] inst_reg, inst_next;

  logic        accept;
  logic        data_accept;
  logic [16:0] len_full;
  logic [15:0] word_idx_inc;

  assign accept       = byte_valid && byte_ready;
  assign data_accept  = accept && (state_reg == DATA);
  assign len_full     = {1'b0, byte_data, n_reg[7:0]};
  assign word_idx_inc = word_idx_reg + 16'd1;

  // Outputs are gated by reset so they take their safe values in the same
  // cycle reset is asserted, not one edge later.
  assign byte_ready = reset && ((state_reg == LEN_LO) || (state_reg == LEN_HI) ||
                                (state_reg == DATA)   || (state_reg == CHK));
  assign write_en   = reset && (state_reg == WRITE);
  assign load_done  = reset && (state_reg == DONE);
  assign load_err   = reset && (state_reg == ERR);
  assign cpu_hold   = !reset || (state_reg != DONE);
  assign address    = {14'd0, word_idx_reg, 2'b00};
  assign write_inst = inst_reg;

  // Byte lane k of the word under assembly takes the k-th data byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign inst_next[8*gi +: 8] = (data_accept && (byte_idx_reg == 2'(gi)))
                                    ? byte_data : inst_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    n_next        = n_reg;
    word_idx_next = word_idx_reg;
    byte_idx_next = byte_idx_reg;
    chk_next      = chk_reg;
    case (state_reg)
      LEN_LO: begin
        if (accept) begin
          n_next     = {8'h00, byte_data};
          state_next = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          n_next = len_full[15:0];
          if (len_full > MAX_WORDS)
            state_next = ERR;
          else if (len_full == 17'd0)
            state_next = CHK;
          else
            state_next = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          byte_idx_next = byte_idx_reg + 2'd1;  // wraps to 0 after lane 3
          chk_next      = chk_reg ^ byte_data;
          if (byte_idx_reg == 2'd3)
            state_next = WRITE;
        end
      end
      WRITE: begin
        // address still shows the old index during the strobe; it advances
        // as we leave.
        word_idx_next = word_idx_inc;
        state_next    = (word_idx_inc == n_reg) ? CHK : DATA;
      end
      CHK: begin
        if (accept)
          state_next = (byte_data == chk_reg) ? DONE : ERR;
      end
      DONE:    state_next = DONE;
      ERR:     state_next = ERR;
      default: state_next = ERR;  // unreachable encoding: fail safe, CPU held
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= LEN_LO;
      n_reg        <= 16'd0;
      word_idx_reg <= 16'd0;
      byte_idx_reg <= 2'd0;
      chk_reg      <= 8'h00;
      inst_reg     <= 32'd0;
    end else begin
      state_reg    <= state_next;
      n_reg        <= n_next;
      word_idx_reg <= word_idx_next;
      byte_idx_reg <= byte_idx_next;
      chk_reg      <= chk_next;
      inst_reg     <= inst_next;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: drives byte streams (with optional random
// valid gaps), records every write strobe, and compares the result with a
// stream-level model of the loader protocol.
module tb_prog_loader;

  localparam int MAX_WORDS = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        write_en;
  logic [31:0] address;
  logic [31:0] write_inst;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .write_en   (write_en),
    .address    (address),
    .write_inst (write_inst),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] got_q[$];   // {address, write_inst} per observed strobe
  logic [63:0] exp_q[$];
  bit          exp_done;
  bit          exp_err;

  // One entry per cycle with write_en high, so a stretched strobe shows up
  // as a duplicate entry.
  always @(negedge clk) begin
    if (write_en) begin
      got_q.push_back({address, write_inst});
      $display("  write addr=%0d data=%08h", address, write_inst);
    end
  end

  // Reference: interpret the stream by the protocol rules.
  function automatic void model(input logic [7:0] s[$]);
    int n;
    logic [7:0] x;
    logic [31:0] w;
    exp_q.delete();
    exp_done = 0;
    exp_err  = 0;
    x = 8'h00;
    n = int'(s[0]) + 256 * int'(s[1]);
    if (n > MAX_WORDS) begin
      exp_err = 1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = {s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]};
      x = x ^ s[2+4*i] ^ s[2+4*i+1] ^ s[2+4*i+2] ^ s[2+4*i+3];
      exp_q.push_back({32'(4 * i), w});
    end
    if (s[2+4*n] == x) exp_done = 1;
    else exp_err = 1;
  endfunction

  task automatic make_prog(input int n, input bit corrupt, output logic [7:0] s[$]);
    logic [7:0] x;
    logic [7:0] b;
    s.delete();
    x = 8'h00;
    s.push_back(8'(n));
    s.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom_range(255));
      s.push_back(b);
      x = x ^ b;
    end
    if (corrupt) x = x ^ 8'($urandom_range(255, 1));
    s.push_back(x);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    got_q.delete();
  endtask

  // Present bytes in order; a byte is consumed once it is shown while
  // byte_ready is high (it is accepted on the following rising edge).
  task automatic send_stream(input logic [7:0] s[$], input int gap_pct);
    int cyc;
    cyc = 0;
    for (int i = 0; i < s.size(); ) begin
      @(negedge clk);
      cyc++;
      if (cyc > 20 * s.size() + 100) begin
        vectors++;
        miscompares++;
        $display("FAIL stream_timeout: accepted %0d bytes, required %0d", i, s.size());
        break;
      end
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        byte_valid = 1'b0;
        continue;
      end
      byte_valid = 1'b1;
      byte_data  = s[i];
      if (byte_ready) i++;
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_end();
    for (int i = 0; i < 20; i++) begin
      if (load_done || load_err) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    byte_valid = 1'b1;
    byte_data = 8'h55;
    repeat (2) @(negedge clk);
    vectors++;
    if ({byte_ready, write_en, cpu_hold, load_done, load_err} !== 5'b00100) begin
      miscompares++;
      $display("FAIL reset_outputs: rdy/we/hold/done/err=%05b required 00100",
               {byte_ready, write_en, cpu_hold, load_done, load_err});
    end
    vectors++;
    if (address !== 32'd0 || write_inst !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_regs: addr=%08h inst=%08h required 0/0", address, write_inst);
    end
    reset = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (byte_ready !== 1'b1 || cpu_hold !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset: ready=%b hold=%b required 1/1", byte_ready, cpu_hold);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic(input bit bad_chk, input int gap_pct);
    logic [7:0] s[$];
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hD0};
    if (bad_chk) s[10] = 8'hD1;
    apply_reset();
    send_stream(s, gap_pct);
    wait_end();
    vectors++;
    if (got_q.size() !== 2) begin
      miscompares++;
      $display("FAIL basic_write_count: got %0d required 2", got_q.size());
    end
    if (got_q.size() >= 2) begin
      vectors++;
      if (got_q[0] !== {32'd0, 32'h00000013} || got_q[1] !== {32'd4, 32'h00500093}) begin
        miscompares++;
        $display("FAIL basic_writes: got %016h %016h required 0000000000000013 0000000400500093",
                 got_q[0], got_q[1]);
      end
    end
    vectors++;
    if ({load_done, load_err, cpu_hold, byte_ready} !== (bad_chk ? 4'b0110 : 4'b1000)) begin
      miscompares++;
      $display("FAIL basic_status(bad=%0d gap=%0d): done/err/hold/rdy=%04b required %04b",
               bad_chk, gap_pct, {load_done, load_err, cpu_hold, byte_ready},
               bad_chk ? 4'b0110 : 4'b1000);
    end
    $display("test_basic bad_chk=%0d gap=%0d done", bad_chk, gap_pct);
  endtask

  task automatic test_empty();
    logic [7:0] s[$];
    s = '{8'h00, 8'h00, 8'h00};
    apply_reset();
    send_stream(s, 0);
    wait_end();
    vectors++;
    if (got_q.size() !== 0 || load_done !== 1'b1 || cpu_hold !== 1'b0 || load_err !== 1'b0) begin
      miscompares++;
      $display("FAIL empty: writes=%0d done=%b hold=%b err=%b required 0/1/0/0",
               got_q.size(), load_done, cpu_hold, load_err);
    end
    $display("test_empty done");
  endtask

  task automatic test_too_long();
    logic [7:0] s[$];
    for (int t = 0; t < 2; t++) begin
      if (t == 0) s = '{8'h01, 8'h01};
      else s = '{8'($urandom_range(255)), 8'($urandom_range(255, 2))};
      apply_reset();
      send_stream(s, 0);
      // Keep offering bytes: none may be taken after the error.
      byte_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (byte_ready !== 1'b0 || load_err !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0) begin
          miscompares++;
          $display("FAIL too_long N=%0d: rdy=%b err=%b hold=%b done=%b required 0/1/1/0",
                   int'(s[0]) + 256 * int'(s[1]), byte_ready, load_err, cpu_hold, load_done);
        end
        @(negedge clk);
      end
      byte_valid = 1'b0;
      vectors++;
      if (got_q.size() !== 0) begin
        miscompares++;
        $display("FAIL too_long_writes: got %0d required 0", got_q.size());
      end
    end
    $display("test_too_long done");
  endtask

  task automatic test_mid_reset();
    logic [7:0] s[$];
    apply_reset();
    s = '{8'h02, 8'h00, 8'h13, 8'h00};
    send_stream(s, 0);
    apply_reset();
    vectors++;
    if (write_inst !== 32'd0 || address !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_reset_clear: inst=%08h addr=%08h required 0/0", write_inst, address);
    end
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hD0};
    send_stream(s, 0);
    wait_end();
    vectors++;
    if (got_q.size() !== 2 || got_q[0] !== {32'd0, 32'h00000013} ||
        got_q[1] !== {32'd4, 32'h00500093} || load_done !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset: writes=%0d done=%b required 2 correct writes and done=1",
               got_q.size(), load_done);
    end
    $display("test_mid_reset done");
  endtask

  task automatic test_random(input int n_lo, input int n_hi, input int runs);
    logic [7:0] s[$];
    int n;
    bit corrupt;
    for (int r = 0; r < runs; r++) begin
      n = $urandom_range(n_hi, n_lo);
      corrupt = ($urandom_range(3) == 0);
      make_prog(n, corrupt, s);
      model(s);
      apply_reset();
      send_stream(s, $urandom_range(40));
      wait_end();
      vectors++;
      if (got_q.size() !== exp_q.size()) begin
        miscompares++;
        $display("FAIL rand_count N=%0d: got %0d writes required %0d", n, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        vectors++;
        if (got_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL rand_write N=%0d #%0d: got %016h required %016h", n, i, got_q[i], exp_q[i]);
        end
      end
      vectors++;
      if (load_done !== exp_done || load_err !== exp_err || cpu_hold !== !exp_done) begin
        miscompares++;
        $display("FAIL rand_status N=%0d: done=%b err=%b hold=%b required %b/%b/%b",
                 n, load_done, load_err, cpu_hold, exp_done, exp_err, !exp_done);
      end
      $display("test_random N=%0d corrupt=%0d writes=%0d", n, corrupt, got_q.size());
    end
  endtask

  task automatic test_max_size();
    test_random(MAX_WORDS, MAX_WORDS, 1);
    vectors++;
    if (got_q.size() == 0 || got_q[got_q.size()-1][63:32] !== 32'd1020) begin
      miscompares++;
      $display("FAIL max_last_addr: got %0d writes, last addr %0d required 1020",
               got_q.size(), got_q.size() == 0 ? 0 : got_q[got_q.size()-1][63:32]);
    end
  endtask

  initial begin
    reset = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    test_reset();
    test_basic(0, 0);
    test_empty();
    test_too_long();
    test_basic(1, 0);
    test_basic(0, 30);
    test_mid_reset();
    test_random(1, 8, 6);
    test_max_size();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, meaning the instruction memory size in bytes; max words = MEM_BYTES/4.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-004 SHALL have port byte_valid  input  1  incoming byte is present.
REQ-005 SHALL have port byte_data  input  8  incoming byte value.
REQ-006 SHALL have port byte_ready  output  1  loader accepts the byte this cycle.
REQ-007 SHALL have port write_en  output  1  instruction memory write strobe.
REQ-008 SHALL have port address  output  32  instruction memory byte address.
REQ-009 SHALL have port write_inst  output  32  instruction word to write.
REQ-010 SHALL have port cpu_hold  output  1  keeps the CPU in reset while loading.
REQ-011 SHALL have port load_done  output  1  program is loaded and verified.
REQ-012 SHALL have port load_err  output  1  length or checksum failure.

Function
REQ-013 SHALL accept a byte only on a cycle with byte_valid=1 and byte_ready=1.
REQ-014 SHALL consume the stream in this order: N_lo, N_hi (16-bit word count N), then 4N data bytes (each word little-endian), then 1 checksum byte.
REQ-015 SHALL use states LEN_LO, LEN_HI, DATA, WRITE, CHK, DONE, ERR.
REQ-016 SHALL assert byte_ready=1 only in LEN_LO, LEN_HI, DATA and CHK, and only while reset is high.
REQ-017 SHALL go LEN_LO->LEN_HI on acceptance of N_lo.
REQ-018 SHALL, on acceptance of N_hi: if N > MEM_BYTES/4 go to ERR; else if N=0 go to CHK; else go to DATA.
REQ-019 SHALL, in DATA, place accepted byte k (k=0..3) into write_inst[8k+7:8k]; acceptance of byte 3 moves to WRITE on the next edge.
REQ-020 SHALL hold write_en=1 for exactly one cycle in WRITE, with address=word_idx*4 and the assembled write_inst.
REQ-021 SHALL, leaving WRITE, increment word_idx, then go to CHK if the new word_idx equals N, else to DATA.
REQ-022 SHALL keep write_en=0 in every state except WRITE.
REQ-023 SHALL drive address=word_idx*4 at all times and hold write_inst between writes.
REQ-024 SHALL keep a running XOR of all data bytes (not length bytes), reset to 0x00.
REQ-025 SHALL, in CHK, go to DONE if the accepted byte equals the running XOR, else go to ERR.
REQ-026 SHALL, in DONE, drive load_done=1 and cpu_hold=0; byte_ready stays 0 and stays so until reset.
REQ-027 SHALL, in ERR, drive load_err=1 and cpu_hold=1; byte_ready stays 0 and stays so until reset.
REQ-028 SHALL drive cpu_hold=1 in every state except DONE.
REQ-029 SHALL allow N=MEM_BYTES/4 (256 by default); the last write goes to address 1020.
REQ-030 SHALL tolerate gaps in byte_valid in any accepting state with no state change; a byte presented during WRITE is not accepted and must remain valid.

Reset
REQ-031 SHALL, while reset=0 at posedge clk, set state=LEN_LO, word_idx=0, byte index=0, checksum=0x00, N=0 and write_inst=0.
REQ-032 SHALL, while reset=0, force byte_ready=0, write_en=0, cpu_hold=1, load_done=0 and load_err=0 combinationally.
REQ-033 SHALL, on reset mid-load, discard partial words; already-written memory contents are not undone.

Verification
REQ-034 SHALL pass: stream 02 00 13 00 00 00 93 00 50 00 D0 -> write 0x00000013 at addr 0 and 0x00500093 at addr 4; then load_done=1, cpu_hold=0, load_err=0.
REQ-035 SHALL pass: stream 00 00 00 -> no write_en pulse; load_done=1.
REQ-036 SHALL pass: stream 01 01 (N=257) -> ERR; load_err=1, byte_ready=0, no write_en pulse, cpu_hold=1.
REQ-037 SHALL pass: scenario REQ-034 with checksum 0xD1 -> both writes occur, then load_err=1 and load_done=0.
REQ-038 SHALL pass: byte_valid held high continuously across a WRITE cycle plus random valid gaps -> identical writes to REQ-034, with no byte lost or duplicated.
REQ-039 SHALL pass: reset pulsed after 2 data bytes, then stream of REQ-034 -> correct writes and load_done=1.
